mips_multicycle_ctrl: RTL and testbench

FSM controller that sequences a shared-memory multicycle MIPS datapath. It has one ALU, one memory port for instructions and data, and IR/A/B/ALUOut/MDR registers. Each instruction is stepped through fetch, decode, execute, memory and writeback states. All datapath enables and mux selects come from the current state. Memory accesses use a ready handshake so the datapath can sit in front of a wait-stated memory.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/aludec.sv | 30 +++
 rtl/mips_multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation classes and datapath mux select values.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX,
    S_JREX,
    S_JALEX
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MEMTOREG_ALU = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR = 2'd1;
  localparam logic [1:0] MEMTOREG_PC  = 2'd2;

  localparam logic [1:0] ALUB_B     = 2'd0;
  localparam logic [1:0] ALUB_FOUR  = 2'd1;
  localparam logic [1:0] ALUB_IMM   = 2'd2;
  localparam logic [1:0] ALUB_IMMSH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's operation class and the R-type funct
// field onto the datapath ALU function code.
module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = 3'b010;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = 3'b010;
      ALUOP_SUB: alucontrol_o = 3'b110;
      ALUOP_FUNCT: begin
        case (funct_i)
          6'b100000: alucontrol_o = 3'b010;
          6'b100010: alucontrol_o = 3'b110;
          6'b100100: alucontrol_o = 3'b000;
          6'b100101: alucontrol_o = 3'b001;
          6'b101010: alucontrol_o = 3'b111;
          default:   alucontrol_o = 3'b010;
        endcase
      end
      default: alucontrol_o = 3'b010;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM sharing one memory port between instruction
// fetch and data access; memory states wait on a ready handshake.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit RESET_PC_HOLD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zeroNzero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic       busy
);

  state_e     state_q, state_d;
  logic       first_fetch_q;
  logic       rdy;
  logic       pcwrite, branch_taken;
  logic       iord_c, memread_c, memwrite_c, irwrite_c, regwrite_c, alusrca_c;
  logic       illegal_c;
  logic [1:0] regdst_c, memtoreg_c, alusrcb_c, pcsrc_c, aluop_c;
  logic [2:0] alucontrol_c;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      first_fetch_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && rdy) first_fetch_q <= 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    pcwrite      = 1'b0;
    branch_taken = 1'b0;
    iord_c       = 1'b0;
    memread_c    = 1'b0;
    memwrite_c   = 1'b0;
    irwrite_c    = 1'b0;
    regdst_c     = REGDST_RT;
    memtoreg_c   = MEMTOREG_ALU;
    regwrite_c   = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = ALUB_B;
    pcsrc_c      = PCSRC_ALU;
    aluop_c      = ALUOP_ADD;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = ALUB_FOUR;
        if (rdy) begin
          irwrite_c = 1'b1;
          pcwrite   = !(RESET_PC_HOLD && first_fetch_q);
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode decodes.
        alusrcb_c = ALUB_IMMSH;
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = (funct == FN_JR) ? S_JREX : S_RTYPEEX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JEX;
          OP_JAL:         state_d = S_JALEX;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = ALUB_IMM;
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_c    = 1'b1;
        memread_c = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg_c = MEMTOREG_MDR;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_c = 1'b1;
        aluop_c   = ALUOP_FUNCT;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst_c   = REGDST_RD;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_c    = 1'b1;
        aluop_c      = ALUOP_SUB;
        pcsrc_c      = PCSRC_ALUOUT;
        branch_taken = ((op == OP_BEQ) && zeroNzero) || ((op == OP_BNE) && !zeroNzero);
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = ALUB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc_c = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_JREX: begin
        pcsrc_c = PCSRC_REG;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_JALEX: begin
        // PC already holds PC+4, so $31 receives the return address.
        pcsrc_c    = PCSRC_JUMP;
        pcwrite    = 1'b1;
        regdst_c   = REGDST_RA;
        memtoreg_c = MEMTOREG_PC;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  aludec u_aludec (
    .aluop_i      (aluop_c),
    .funct_i      (funct),
    .alucontrol_o (alucontrol_c)
  );

  // Reset gates every output combinationally so a pending write drops at once.
  assign pcen       = reset & (pcwrite | branch_taken);
  assign iord       = reset & iord_c;
  assign memread    = reset & memread_c;
  assign memwrite   = reset & memwrite_c;
  assign irwrite    = reset & irwrite_c;
  assign regdst     = reset ? regdst_c : 2'b00;
  assign memtoreg   = reset ? memtoreg_c : 2'b00;
  assign regwrite   = reset & regwrite_c;
  assign alusrca    = reset & alusrca_c;
  assign alusrcb    = reset ? alusrcb_c : 2'b00;
  assign pcsrc      = reset ? pcsrc_c : 2'b00;
  assign alucontrol = reset ? alucontrol_c : 3'b000;
  assign illegal_op = reset & illegal_c;
  assign busy       = reset & (state_q != S_FETCH);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS controller: per-cycle vector table,
// reset abort during a stalled store, and per-instruction cycle counts.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic       busy;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zeroNzero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pcen, iord, memread, memwrite, irwrite, regwrite, alusrca, illegal_op, busy;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic [2:0] alucontrol;
  out_t       act;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zeroNzero  (zeroNzero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op),
    .busy       (busy)
  );

  assign act = {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, alucontrol, illegal_op, busy};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JJ = 6'b000010, JAL = 6'b000011;
  localparam logic [5:0] BADOP = 6'b111111;

  function automatic out_t o_rst();
    out_t o; o = '0; return o;
  endfunction
  function automatic out_t o_base();
    out_t o; o = '0; o.busy = 1'b1; o.alucontrol = 3'b010; return o;
  endfunction
  function automatic out_t o_fetch(logic r);
    out_t o; o = '0;
    o.memread = 1'b1; o.alusrcb = 2'd1; o.alucontrol = 3'b010;
    o.irwrite = r; o.pcen = r;
    return o;
  endfunction
  function automatic out_t o_decode(logic ill);
    out_t o; o = o_base(); o.alusrcb = 2'd3; o.illegal_op = ill; return o;
  endfunction
  function automatic out_t o_memadr();
    out_t o; o = o_base(); o.alusrca = 1'b1; o.alusrcb = 2'd2; return o;
  endfunction
  function automatic out_t o_memrd();
    out_t o; o = o_base(); o.iord = 1'b1; o.memread = 1'b1; return o;
  endfunction
  function automatic out_t o_memwb();
    out_t o; o = o_base(); o.memtoreg = 2'd1; o.regwrite = 1'b1; return o;
  endfunction
  function automatic out_t o_memwr();
    out_t o; o = o_base(); o.iord = 1'b1; o.memwrite = 1'b1; return o;
  endfunction
  function automatic out_t o_rtex(logic [2:0] alu);
    out_t o; o = o_base(); o.alusrca = 1'b1; o.alucontrol = alu; return o;
  endfunction
  function automatic out_t o_rtwb();
    out_t o; o = o_base(); o.regdst = 2'd1; o.regwrite = 1'b1; return o;
  endfunction
  function automatic out_t o_branch(logic taken);
    out_t o; o = o_base();
    o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'd1; o.pcen = taken;
    return o;
  endfunction
  function automatic out_t o_addiex();
    out_t o; o = o_base(); o.alusrca = 1'b1; o.alusrcb = 2'd2; return o;
  endfunction
  function automatic out_t o_addiwb();
    out_t o; o = o_base(); o.regwrite = 1'b1; return o;
  endfunction
  function automatic out_t o_jex();
    out_t o; o = o_base(); o.pcsrc = 2'd2; o.pcen = 1'b1; return o;
  endfunction
  function automatic out_t o_jrex();
    out_t o; o = o_base(); o.pcsrc = 2'd3; o.pcen = 1'b1; return o;
  endfunction
  function automatic out_t o_jalex();
    out_t o; o = o_base();
    o.pcsrc = 2'd2; o.pcen = 1'b1; o.regdst = 2'd2; o.memtoreg = 2'd2; o.regwrite = 1'b1;
    return o;
  endfunction

  task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic r, input out_t e);
    vec_t v;
    v.rst = rst; v.op = o; v.fn = f; v.zero = z; v.rdy = r; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check_out(input string name, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Entered mid FETCH; counts cycles until the controller returns to FETCH.
  task automatic count_cycles(input string name, input logic [5:0] o, input logic [5:0] f,
                              input int want);
    int n;
    op = o; funct = f; mem_ready = 1'b1; zeroNzero = 1'b0;
    #1;
    check_int({name, "_start_fetch"}, int'(busy), 0);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (!busy) break;
      n++;
    end
    check_int({name, "_cycles"}, n, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) add(0, 6'd0, 6'd0, 0, 1, o_rst());
    // lw with two wait states in MEMRD
    add(1, LW, 0, 0, 1, o_fetch(1));
    add(1, LW, 0, 0, 1, o_decode(0));
    add(1, LW, 0, 0, 1, o_memadr());
    add(1, LW, 0, 0, 0, o_memrd());
    add(1, LW, 0, 0, 0, o_memrd());
    add(1, LW, 0, 0, 1, o_memrd());
    add(1, LW, 0, 0, 1, o_memwb());
    // slt with one fetch wait state
    add(1, RT, 6'b101010, 0, 0, o_fetch(0));
    add(1, RT, 6'b101010, 0, 1, o_fetch(1));
    add(1, RT, 6'b101010, 0, 1, o_decode(0));
    add(1, RT, 6'b101010, 0, 1, o_rtex(3'b111));
    add(1, RT, 6'b101010, 0, 1, o_rtwb());
    add(1, RT, 6'b100000, 0, 1, o_fetch(1));
    add(1, RT, 6'b100000, 0, 1, o_decode(0));
    add(1, RT, 6'b100000, 0, 1, o_rtex(3'b010));
    add(1, RT, 6'b100000, 0, 1, o_rtwb());
    add(1, BEQ, 0, 1, 1, o_fetch(1));
    add(1, BEQ, 0, 1, 1, o_decode(0));
    add(1, BEQ, 0, 1, 1, o_branch(1));
    add(1, BNE, 0, 1, 1, o_fetch(1));
    add(1, BNE, 0, 1, 1, o_decode(0));
    add(1, BNE, 0, 1, 1, o_branch(0));
    add(1, BNE, 0, 0, 1, o_fetch(1));
    add(1, BNE, 0, 0, 1, o_decode(0));
    add(1, BNE, 0, 0, 1, o_branch(1));
    add(1, BEQ, 0, 0, 1, o_fetch(1));
    add(1, BEQ, 0, 0, 1, o_decode(0));
    add(1, BEQ, 0, 0, 1, o_branch(0));
    add(1, ADDI, 0, 0, 1, o_fetch(1));
    add(1, ADDI, 0, 0, 1, o_decode(0));
    add(1, ADDI, 0, 0, 1, o_addiex());
    add(1, ADDI, 0, 0, 1, o_addiwb());
    add(1, JJ, 0, 0, 1, o_fetch(1));
    add(1, JJ, 0, 0, 1, o_decode(0));
    add(1, JJ, 0, 0, 1, o_jex());
    add(1, JAL, 0, 0, 1, o_fetch(1));
    add(1, JAL, 0, 0, 1, o_decode(0));
    add(1, JAL, 0, 0, 1, o_jalex());
    add(1, RT, 6'b001000, 0, 1, o_fetch(1));
    add(1, RT, 6'b001000, 0, 1, o_decode(0));
    add(1, RT, 6'b001000, 0, 1, o_jrex());
    add(1, BADOP, 0, 0, 1, o_fetch(1));
    add(1, BADOP, 0, 0, 1, o_decode(1));
    add(1, SW, 0, 0, 1, o_fetch(1));
    add(1, SW, 0, 0, 1, o_decode(0));
    add(1, SW, 0, 0, 1, o_memadr());
    add(1, SW, 0, 0, 1, o_memwr());

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; op = tbl[i].op; funct = tbl[i].fn;
      zeroNzero = tbl[i].zero; mem_ready = tbl[i].rdy;
      #1;
      check_out($sformatf("step%0d", i), tbl[i].exp);
    end

    // Stalled store aborted by reset between clock edges
    @(negedge clk); op = SW; funct = 0; mem_ready = 1'b1; #1;
    check_out("sw_fetch", o_fetch(1));
    @(negedge clk); #1; check_out("sw_decode", o_decode(0));
    @(negedge clk); #1; check_out("sw_memadr", o_memadr());
    @(negedge clk); mem_ready = 1'b0; #1; check_out("sw_wait0", o_memwr());
    @(negedge clk); #1; check_out("sw_wait1", o_memwr());
    #2; reset = 1'b0; #1;
    check_out("sw_abort_async", o_rst());
    @(negedge clk); #1; check_out("sw_abort_held", o_rst());
    @(negedge clk); reset = 1'b1; #1;
    check_out("post_abort_fetch_nordy", o_fetch(0));
    mem_ready = 1'b1; #1;
    check_out("post_abort_fetch_rdy", o_fetch(1));

    count_cycles("lw", LW, 0, 5);
    count_cycles("sw", SW, 0, 4);
    count_cycles("rtype", RT, 6'b100010, 4);
    count_cycles("addi", ADDI, 0, 4);
    count_cycles("beq", BEQ, 0, 3);
    count_cycles("bne", BNE, 0, 3);
    count_cycles("j", JJ, 0, 3);
    count_cycles("jr", RT, 6'b001000, 3);
    count_cycles("jal", JAL, 0, 3);
    count_cycles("illegal", BADOP, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
